// File: rtl/seg_bus_decoder.sv
// Purpose: snoops a multiplexed 7-segment/anode bus and rebuilds the 4-digit value it shows (optional SEG_BUS_DECODER_ERRCNT_EN adds err_count).
// Latency: a digit is captured after STABLE_CYCLES unchanged cycles; frame_valid follows the completing capture by one cycle.
// Backpressure: none, passive monitor; outputs are pulses/held values and the observed bus is never stalled.
module seg_bus_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         seg_in,
    input  logic [3:0]         an_in,
    output logic signed [14:0] value,
    output logic               neg,
    output logic               frame_valid,
    output logic               err
`ifdef SEG_BUS_DECODER_ERRCNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        hist_q;
    logic [7:0]         cnt_q;
    logic [3:0]         mask_q;
    logic [3:0]         slot_q [4];
    logic               minus3_q;
    logic signed [14:0] value_q;
    logic               neg_q;
    logic               err_q;

    logic               qualify;
    logic               same;
    logic [1:0]         idx;
    logic [3:0]         sel;
    logic               dig_legal;
    logic               dig_minus;
    logic [3:0]         dig_val;
    logic               cap;
    logic               cap_bad;
    logic               cap_ok;
    logic [3:0]         mask_upd;
    logic [14:0]        low3;
    logic [14:0]        full4;
    logic signed [14:0] emit_val;

    // Anode qualification: exactly one digit driver active selects a slot.
    always_comb begin
        qualify = 1'b1;
        idx     = 2'd0;
        sel     = 4'b0000;
        case (an_in)
            4'b1110: begin idx = 2'd0; sel = 4'b0001; end
            4'b1101: begin idx = 2'd1; sel = 4'b0010; end
            4'b1011: begin idx = 2'd2; sel = 4'b0100; end
            4'b0111: begin idx = 2'd3; sel = 4'b1000; end
            default: qualify = 1'b0;
        endcase
    end

    // Segment pattern decode (active-low, {g..a}); anything unlisted is illegal.
    always_comb begin
        dig_legal = 1'b1;
        dig_minus = 1'b0;
        dig_val   = 4'd0;
        case (seg_in)
            7'h40: dig_val = 4'd0;
            7'h79: dig_val = 4'd1;
            7'h24: dig_val = 4'd2;
            7'h30: dig_val = 4'd3;
            7'h19: dig_val = 4'd4;
            7'h12: dig_val = 4'd5;
            7'h02: dig_val = 4'd6;
            7'h78: dig_val = 4'd7;
            7'h00: dig_val = 4'd8;
            7'h10: dig_val = 4'd9;
            7'h3F: dig_minus = 1'b1;
            7'h7F: dig_val = 4'd0;
            default: dig_legal = 1'b0;
        endcase
    end

    // Capture fires on the single cycle the run length reaches STABLE_CYCLES-1.
    always_comb begin
        same     = ({seg_in, an_in} == hist_q);
        cap      = qualify && same && (cnt_q == 8'(STABLE_CYCLES - 2));
        cap_bad  = cap && (!dig_legal || (dig_minus && (idx != 2'd3)));
        cap_ok   = cap && !cap_bad;
        mask_upd = ((state_q == EMIT) ? 4'b0000 : mask_q) | sel;
    end

    // Frame value assembled from the slots; minus in slot 3 negates the low three digits.
    always_comb begin
        low3     = 15'(slot_q[2]) * 15'd100 + 15'(slot_q[1]) * 15'd10 + 15'(slot_q[0]);
        full4    = 15'(slot_q[3]) * 15'd1000 + low3;
        emit_val = minus3_q ? -$signed(low3) : $signed(full4);
    end

    // Stability tracking: history of last pair plus saturating run counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 11'd0;
            cnt_q  <= 8'd0;
        end else begin
            hist_q <= {seg_in, an_in};
            if (qualify && same) begin
                cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_q <= 8'd0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and frame_valid; a capture in EMIT opens the next frame.
    always_comb begin
        state_d     = state_q;
        frame_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap_ok) state_d = COLLECT;
            end
            COLLECT: begin
                if (cap_bad)                            state_d = IDLE;
                else if (cap_ok && mask_upd == 4'b1111) state_d = EMIT;
            end
            EMIT: begin
                frame_valid = 1'b1;
                state_d     = cap_ok ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot/mask datapath, error pulse and held output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q   <= 4'd0;
            slot_q   <= '{4'd0, 4'd0, 4'd0, 4'd0};
            minus3_q <= 1'b0;
            err_q    <= 1'b0;
            value_q  <= 15'sd0;
            neg_q    <= 1'b0;
        end else begin
            err_q <= cap_bad;
            if (cap_bad) begin
                mask_q   <= 4'd0;
                slot_q   <= '{4'd0, 4'd0, 4'd0, 4'd0};
                minus3_q <= 1'b0;
            end else if (cap_ok) begin
                mask_q      <= mask_upd;
                slot_q[idx] <= dig_val;
                if (idx == 2'd3) minus3_q <= dig_minus;
            end else if (state_q == EMIT) begin
                mask_q <= 4'd0;
            end
            if (state_q == EMIT) begin
                value_q <= emit_val;
                neg_q   <= minus3_q;
            end
        end
    end

    assign value = (state_q == EMIT) ? emit_val : value_q;
    assign neg   = (state_q == EMIT) ? minus3_q : neg_q;
    assign err   = err_q;

`ifdef SEG_BUS_DECODER_ERRCNT_EN
    // Saturating count of discarded frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (cap_bad && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
